// File: rtl/mac_seq_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// mac_seq_ctrl_pkg
//   Shared definitions for the FP16 dot-product sequencer: the FP16 word
//   width, the FP16 zero encoding and the controller state encoding.
//   Optional feature macro used by the slice: MAC_PIPE_EN (pipelined mac_unit).
// ---------------------------------------------------------------------------
package mac_seq_ctrl_pkg;

    localparam int                FP16_W    = 16;
    localparam logic [FP16_W-1:0] FP16_ZERO = 16'h0000;

    // ST_WAIT is only reachable when the external mac_unit is pipelined.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_FEED = 2'd1,
        ST_WAIT = 2'd2,
        ST_DONE = 2'd3
    } state_t;

endpackage

// File: rtl/mac_seq_ctrl_if.sv
// ---------------------------------------------------------------------------
// mac_seq_ctrl_if
//   Bundles the command, operand stream, result stream and mac_unit side
//   signals of mac_seq_ctrl.
//   Modports:
//     slave  - the controller (mac_seq_ctrl)
//     master - the surrounding logic (operand buffers, result sink, mac_unit)
//   Signals:
//     start, cfg_len, cfg_bias          command / configuration
//     busy                              controller not idle
//     in_valid, in_ready, in_a, in_b    operand pair stream
//     out_valid, out_ready, out_data    result stream
//     mac_a, mac_b, mac_c, mac_out      connection to the external mac_unit
// ---------------------------------------------------------------------------
interface mac_seq_ctrl_if #(
    parameter int LEN_W = 8
);
    import mac_seq_ctrl_pkg::*;

    logic              start;
    logic [LEN_W-1:0]  cfg_len;
    logic [FP16_W-1:0] cfg_bias;
    logic              busy;

    logic              in_valid;
    logic              in_ready;
    logic [FP16_W-1:0] in_a;
    logic [FP16_W-1:0] in_b;

    logic              out_valid;
    logic              out_ready;
    logic [FP16_W-1:0] out_data;

    logic [FP16_W-1:0] mac_a;
    logic [FP16_W-1:0] mac_b;
    logic [FP16_W-1:0] mac_c;
    logic [FP16_W-1:0] mac_out;

    modport slave (
        input  start, cfg_len, cfg_bias,
        input  in_valid, in_a, in_b,
        input  out_ready,
        input  mac_out,
        output busy, in_ready, out_valid, out_data,
        output mac_a, mac_b, mac_c
    );

    modport master (
        output start, cfg_len, cfg_bias,
        output in_valid, in_a, in_b,
        output out_ready,
        output mac_out,
        input  busy, in_ready, out_valid, out_data,
        input  mac_a, mac_b, mac_c
    );

endinterface

// File: rtl/mac_seq_ctrl.sv
// ---------------------------------------------------------------------------
// mac_seq_ctrl
//   Sequences a K-element FP16 dot product acc = bias + sum(a[i]*b[i])
//   through one shared, externally instantiated mac_unit. The running
//   accumulator is fed back as the MAC adder input on every step. The
//   controller only routes FP16 words; it never modifies their bits.
//
//   Parameters:
//     LEN_W   width of cfg_len (max vector length 2**LEN_W-1)
//     MAC_LAT mac_unit latency, 1..15 (only used with MAC_PIPE_EN)
//   Ports:
//     clk     clock, rising edge
//     rst_n   asynchronous reset, active-low
//     clr     synchronous soft clear back to IDLE, drops any pending result
//     bus     mac_seq_ctrl_if.slave: command, operand stream, result stream
//             and mac_unit connection
//   Configuration macro:
//     MAC_PIPE_EN  undefined: combinational mac_unit, 1 element per cycle
//                  defined:   pipelined mac_unit, each element waits MAC_LAT
//                             cycles in WAIT with the MAC inputs held stable
// ---------------------------------------------------------------------------
module mac_seq_ctrl
    import mac_seq_ctrl_pkg::*;
#(
    parameter int LEN_W   = 8,
    parameter int MAC_LAT = 2
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clr,
    mac_seq_ctrl_if.slave bus
);

    state_t            state;
    state_t            state_d;

    logic [FP16_W-1:0] acc;
    logic [LEN_W-1:0]  cnt;
    logic [LEN_W-1:0]  len;

    logic              accept;
    logic              last_feed;

`ifdef MAC_PIPE_EN
    logic [FP16_W-1:0] op_a;
    logic [FP16_W-1:0] op_b;
    logic [3:0]        wcnt;
    logic              wait_end;
    logic              last_wait;

    assign wait_end  = (wcnt == 4'(MAC_LAT - 1));
    // cnt was already advanced on accept, so the final element is cnt==len.
    assign last_wait = (cnt == len);
`endif

    assign accept    = bus.in_valid && (state == ST_FEED);
    assign last_feed = (cnt == len - LEN_W'(1));

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_d;
        end
    end

    // Next state and outputs
    always_comb begin
        state_d       = state;
        bus.busy      = (state != ST_IDLE);
        bus.in_ready  = 1'b0;
        bus.out_valid = 1'b0;
        bus.out_data  = FP16_ZERO;
        bus.mac_a     = FP16_ZERO;
        bus.mac_b     = FP16_ZERO;
        bus.mac_c     = FP16_ZERO;

        case (state)
            ST_IDLE: begin
                if (bus.start) begin
                    state_d = (bus.cfg_len != '0) ? ST_FEED : ST_DONE;
                end
            end

            ST_FEED: begin
                bus.in_ready = 1'b1;
                bus.mac_a    = bus.in_a;
                bus.mac_b    = bus.in_b;
                bus.mac_c    = acc;
                if (accept) begin
`ifdef MAC_PIPE_EN
                    state_d = ST_WAIT;
`else
                    state_d = last_feed ? ST_DONE : ST_FEED;
`endif
                end
            end

            ST_WAIT: begin
`ifdef MAC_PIPE_EN
                // Registered operands keep the MAC inputs frozen for MAC_LAT cycles.
                bus.mac_a = op_a;
                bus.mac_b = op_b;
                bus.mac_c = acc;
                if (wait_end) begin
                    state_d = last_wait ? ST_DONE : ST_FEED;
                end
`else
                state_d = ST_IDLE;
`endif
            end

            ST_DONE: begin
                bus.out_valid = 1'b1;
                bus.out_data  = acc;
                if (bus.out_ready) begin
                    state_d = ST_IDLE;
                end
            end

            default: state_d = ST_IDLE;
        endcase

        if (clr) begin
            state_d = ST_IDLE;
        end
    end

    // Accumulator, element counter and operand registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc  <= FP16_ZERO;
            cnt  <= '0;
            len  <= '0;
`ifdef MAC_PIPE_EN
            op_a <= FP16_ZERO;
            op_b <= FP16_ZERO;
            wcnt <= '0;
`endif
        end else if (clr) begin
            acc  <= FP16_ZERO;
            cnt  <= '0;
`ifdef MAC_PIPE_EN
            op_a <= FP16_ZERO;
            op_b <= FP16_ZERO;
            wcnt <= '0;
`endif
        end else begin
            case (state)
                ST_IDLE: begin
                    if (bus.start) begin
                        acc <= bus.cfg_bias;
                        if (bus.cfg_len != '0) begin
                            len <= bus.cfg_len;
                            cnt <= '0;
                        end
                    end
                end

                ST_FEED: begin
                    if (accept) begin
                        cnt <= cnt + LEN_W'(1);
`ifdef MAC_PIPE_EN
                        op_a <= bus.in_a;
                        op_b <= bus.in_b;
                        wcnt <= '0;
`else
                        acc  <= bus.mac_out;
`endif
                    end
                end

`ifdef MAC_PIPE_EN
                ST_WAIT: begin
                    if (wait_end) begin
                        acc  <= bus.mac_out;
                        wcnt <= '0;
                    end else begin
                        wcnt <= wcnt + 4'd1;
                    end
                end
`endif

                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mac_seq_ctrl.sv
// ---------------------------------------------------------------------------
// tb_mac_seq_ctrl
//   Self-checking bench for mac_seq_ctrl. A behavioural FP16 multiply-add
//   stands in for the external mac_unit. Expected dot-product results are
//   queued when a run is started and compared when the result handshake
//   occurs. Build with +define+MAC_PIPE_EN to exercise the pipelined mode.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_mac_seq_ctrl;
    import mac_seq_ctrl_pkg::*;

    localparam int LEN_W   = 8;
    localparam int MAC_LAT = 2;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic clr   = 1'b0;

    mac_seq_ctrl_if #(.LEN_W(LEN_W)) bus ();

    mac_seq_ctrl #(
        .LEN_W  (LEN_W),
        .MAC_LAT(MAC_LAT)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .clr  (clr),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int pop_cyc = 0;
    int rdy_cnt = 0;

    logic [15:0] exp_q[$];
    logic [15:0] pa[8];
    logic [15:0] pb[8];
    int          acc_cyc[8];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, want %h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // ---------------- behavioural FP16 mac_unit ----------------
    function automatic real pow2(input int e);
        real v = 1.0;
        if (e >= 0) for (int i = 0; i < e; i++) v = v * 2.0;
        else        for (int i = 0; i < -e; i++) v = v / 2.0;
        return v;
    endfunction

    function automatic real h2r(input logic [15:0] h);
        real v;
        if (h[14:10] == 5'd0) v = real'(h[9:0]) * pow2(-24);
        else v = (1.0 + real'(h[9:0]) / 1024.0) * pow2(int'(h[14:10]) - 15);
        return h[15] ? -v : v;
    endfunction

    function automatic logic [15:0] r2h(input real r);
        logic s;
        int   e;
        int   m;
        real  x;
        if (r == 0.0) return 16'h0000;
        s = (r < 0.0);
        x = s ? -r : r;
        e = 15;
        while (x >= 2.0 && e < 64)  begin x = x / 2.0; e++; end
        while (x < 1.0  && e > -64) begin x = x * 2.0; e--; end
        m = $rtoi((x - 1.0) * 1024.0 + 0.5);
        if (m == 1024) begin m = 0; e++; end
        if (e >= 31) return {s, 5'h1f, 10'h000};
        if (e <= 0)  return {s, 15'h0000};
        return {s, e[4:0], m[9:0]};
    endfunction

    always_comb bus.mac_out = r2h(h2r(bus.mac_a) * h2r(bus.mac_b) + h2r(bus.mac_c));

    // ---------------- scoreboard monitor ----------------
    always @(negedge clk) begin
        if (rst_n && bus.in_ready) rdy_cnt++;
        if (rst_n && bus.out_valid && bus.out_ready) begin
            if (exp_q.size() == 0) begin
                chk("sb_unexpected_result", {16'h0, bus.out_data}, 32'hFFFF_FFFF);
            end else begin
                chk("sb_out_data", {16'h0, bus.out_data}, {16'h0, exp_q.pop_front()});
                pop_cyc = cyc;
            end
        end
    end

    // ---------------- stimulus tasks (entered/left at posedge+1) ----------------
    task automatic do_start(input logic [7:0] len, input logic [15:0] bias,
                            input logic [15:0] exp, input bit push);
        bus.start    = 1'b1;
        bus.cfg_len  = len;
        bus.cfg_bias = bias;
        if (push) exp_q.push_back(exp);
        @(posedge clk); #1;
        bus.start    = 1'b0;
    endtask

    task automatic feed(input int n, input bit toggle);
        int i     = 0;
        int guard = 0;
        bit ph    = 1'b1;
        bit took;
        while (i < n && guard < 200) begin
            bus.in_valid = toggle ? ph : 1'b1;
            bus.in_a     = pa[i];
            bus.in_b     = pb[i];
            @(negedge clk);
            took = bus.in_valid && bus.in_ready;
            if (took) begin
                acc_cyc[i] = cyc;
                chk("mac_a_follows_in_a", {16'h0, bus.mac_a}, {16'h0, pa[i]});
            end
            @(posedge clk); #1;
            if (took) i++;
            ph = ~ph;
            guard++;
        end
        bus.in_valid = 1'b0;
        if (i < n) chk("feed_timeout", i, n);
    endtask

    task automatic wait_idle();
        int g = 0;
        while ((exp_q.size() != 0 || bus.busy) && g < 100) begin
            @(negedge clk);
            g++;
        end
        if (g >= 100) chk("wait_idle_timeout", g, 0);
        @(posedge clk); #1;
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: got hung, want finished");
        $fatal(1, "bench did not finish");
    end

    initial begin
        int g;
        bus.start     = 1'b0;
        bus.cfg_len   = '0;
        bus.cfg_bias  = 16'h0;
        bus.in_valid  = 1'b0;
        bus.in_a      = 16'h0;
        bus.in_b      = 16'h0;
        bus.out_ready = 1'b1;

        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        // Reset state
        @(negedge clk);
        chk("rst_busy",      bus.busy,      0);
        chk("rst_in_ready",  bus.in_ready,  0);
        chk("rst_out_valid", bus.out_valid, 0);
        chk("rst_out_data",  bus.out_data,  0);
        chk("rst_mac_c",     bus.mac_c,     0);
        @(posedge clk); #1;

        // 1: len=3, 1.0*2.0 x3 -> 6.0
        for (int i = 0; i < 3; i++) begin pa[i] = 16'h3C00; pb[i] = 16'h4000; end
        do_start(8'd3, 16'h0000, 16'h4600, 1'b1);
        feed(3, 1'b0);
        wait_idle();
`ifndef MAC_PIPE_EN
        chk("t1_consecutive_accepts", acc_cyc[2] - acc_cyc[0], 2);
        chk("t1_result_latency",      pop_cyc - acc_cyc[2],    1);
`endif

        // 2: len=0 returns the bias directly
        rdy_cnt = 0;
        do_start(8'd0, 16'h4200, 16'h4200, 1'b1);
        @(negedge clk);
        chk("t2_out_valid_next", bus.out_valid, 1);
        chk("t2_busy",           bus.busy,      1);
        @(posedge clk); #1;
        wait_idle();
        chk("t2_no_in_ready", rdy_cnt, 0);

        // 3: 1.0 + 2.0*0.5 + 3.0*2.0 = 8.0, held while out_ready low
        bus.out_ready = 1'b0;
        pa[0] = 16'h4000; pb[0] = 16'h3800;
        pa[1] = 16'h4200; pb[1] = 16'h4000;
        do_start(8'd2, 16'h3C00, 16'h4800, 1'b1);
        feed(2, 1'b0);
        g = 0;
        while (!bus.out_valid && g < 20) begin @(negedge clk); g++; end
        if (g >= 20) chk("t3_out_valid_timeout", g, 0);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("t3_hold_valid", bus.out_valid, 1);
            chk("t3_hold_data",  bus.out_data,  16'h4800);
            @(posedge clk); #1;
            bus.start   = k[0];
            bus.cfg_len = 8'd3;
        end
        bus.start     = 1'b0;
        bus.out_ready = 1'b1;
        wait_idle();
        @(negedge clk);
        chk("t3_start_ignored_a", bus.busy, 0);
        @(negedge clk);
        chk("t3_start_ignored_b", bus.busy, 0);
        @(posedge clk); #1;

        // 4: len=4, 1.0*1.0 x4 with in_valid toggling -> 4.0
        for (int i = 0; i < 4; i++) begin pa[i] = 16'h3C00; pb[i] = 16'h3C00; end
        do_start(8'd4, 16'h0000, 16'h4400, 1'b1);
        feed(4, 1'b1);
        wait_idle();
`ifndef MAC_PIPE_EN
        chk("t4_accept_spacing", acc_cyc[3] - acc_cyc[0], 6);
`endif

        // 5: clr after the 2nd accept of a len=5 run discards the result
        for (int i = 0; i < 5; i++) begin pa[i] = 16'h3C00; pb[i] = 16'h4000; end
        do_start(8'd5, 16'h0000, 16'h0000, 1'b0);
        feed(2, 1'b0);
        clr = 1'b1;
        @(posedge clk); #1;
        clr = 1'b0;
        @(negedge clk);
        chk("t5_clr_busy",      bus.busy,      0);
        chk("t5_clr_in_ready",  bus.in_ready,  0);
        chk("t5_clr_out_valid", bus.out_valid, 0);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("t5_no_out_valid", bus.out_valid, 0);
        end
        @(posedge clk); #1;
        pa[0] = 16'h4000; pb[0] = 16'h4000;
        do_start(8'd1, 16'h0000, 16'h4400, 1'b1);
        feed(1, 1'b0);
        wait_idle();

`ifdef MAC_PIPE_EN
        // 6: pipelined MAC, len=2, 1.0*2.0 x2 -> 4.0
        begin
            logic [5:0] rdy_pat;
            rdy_pat = '0;
            do_start(8'd2, 16'h0000, 16'h4400, 1'b1);
            for (int k = 0; k < 6; k++) begin
                bus.in_valid = 1'b1;
                bus.in_a     = (k == 0 || k == 3) ? 16'h3C00 : 16'h7BFF;
                bus.in_b     = (k == 0 || k == 3) ? 16'h4000 : 16'h0000;
                @(negedge clk);
                rdy_pat[k] = bus.in_ready;
                if (k == 1 || k == 2 || k == 4 || k == 5) begin
                    chk("t6_wait_mac_a", bus.mac_a, 16'h3C00);
                    chk("t6_wait_mac_b", bus.mac_b, 16'h4000);
                    chk("t6_wait_mac_c", bus.mac_c, (k < 3) ? 16'h0000 : 16'h4000);
                end
                @(posedge clk); #1;
            end
            bus.in_valid = 1'b0;
            chk("t6_in_ready_pattern", rdy_pat, 6'b001001);
            wait_idle();
        end
`endif

        chk("sb_queue_drained", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
